regs_alu_cp0: RTL and testbench

- Execution core of the multicycle MIPS datapath: 32x32 general register file, 32-bit ALU and CP0 coprocessor register bank, in one block.
- Controller drives register addresses, ALU operation and CP0 write strobes.
- Block returns operand reads, ALU result and flags, CP0 read data and EPC for exception return.
- Ports keep the signal names the datapath already uses.

---
 rtl/regs_alu_cp0_pkg.sv | 33 +++
 rtl/regs_alu_cp0_if.sv | 56 +++++
 rtl/regs_alu_cp0_alu_unit.sv | 60 ++++++
 rtl/regs_alu_cp0.sv | 72 +++++++
 tb/tb_regs_alu_cp0.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/regs_alu_cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regs_alu_cp0_pkg
// Description : Shared constants for the execution core: ALU opcodes, CP0
//               register indices and datapath width.
// Revision    : 1.0  initial release
// ============================================================================
package regs_alu_cp0_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_ADDU = 4'b1011;
    localparam logic [3:0] ALU_SUBU = 4'b1100;
    localparam logic [3:0] ALU_SLLV = 4'b1101;
    localparam logic [3:0] ALU_SRLV = 4'b1110;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    localparam int CP0_CAUSE = 13;
    localparam int CP0_EPC   = 14;

endpackage : regs_alu_cp0_pkg
`default_nettype wire

// File: rtl/regs_alu_cp0_if.sv
`default_nettype none
// ============================================================================
// Module      : regs_alu_cp0_if
// Description : Controller <-> execution core signal bundle. The master side
//               is the controller/datapath, the slave side is the core.
// Revision    : 1.0  initial release
// ============================================================================
interface regs_alu_cp0_if;
    import regs_alu_cp0_pkg::*;

    // GPR file
    logic [4:0]        reg_R_addr_A;
    logic [4:0]        reg_R_addr_B;
    logic [4:0]        reg_W_addr;
    logic [DATA_W-1:0] wdata;
    logic              reg_we;
    logic [DATA_W-1:0] rdata_A;
    logic [DATA_W-1:0] rdata_B;
    // ALU
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [3:0]        ALU_operation;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              overflow;
    // CP0
    logic [4:0]        c0_rd_addr;
    logic [4:0]        c0_wr_addr;
    logic [DATA_W-1:0] c0_w_data;
    logic              c0_reg_we;
    logic [DATA_W-1:0] pc_i;
    logic [4:0]        InTcause;
    logic              WriteEPC;
    logic              WriteCause;
    logic [DATA_W-1:0] c0_r_data;
    logic [DATA_W-1:0] epc_o;

    modport master (
        output reg_R_addr_A, reg_R_addr_B, reg_W_addr, wdata, reg_we,
        output A, B, ALU_operation, shamt,
        output c0_rd_addr, c0_wr_addr, c0_w_data, c0_reg_we,
        output pc_i, InTcause, WriteEPC, WriteCause,
        input  rdata_A, rdata_B, res, zero, overflow, c0_r_data, epc_o
    );

    modport slave (
        input  reg_R_addr_A, reg_R_addr_B, reg_W_addr, wdata, reg_we,
        input  A, B, ALU_operation, shamt,
        input  c0_rd_addr, c0_wr_addr, c0_w_data, c0_reg_we,
        input  pc_i, InTcause, WriteEPC, WriteCause,
        output rdata_A, rdata_B, res, zero, overflow, c0_r_data, epc_o
    );

endinterface : regs_alu_cp0_if
`default_nettype wire

// File: rtl/regs_alu_cp0_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit
// Description : Combinational 32-bit MIPS ALU with zero and signed-overflow
//               flags. Arithmetic wraps modulo 2^32.
// Revision    : 1.0  initial release
// ============================================================================
module alu_unit
    import regs_alu_cp0_pkg::*;
(
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    input  wire logic [3:0]        op,
    input  wire logic [4:0]        shamt,
    output logic      [DATA_W-1:0] res,
    output logic                   zero,
    output logic                   overflow
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Result mux and overflow detection for the signed add/sub ops
    always_comb begin
        res      = '0;
        overflow = 1'b0;
        case (op)
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_ADD: begin
                res      = sum;
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_SRL:  res = b >> shamt;
            ALU_SUB: begin
                res      = diff;
                overflow = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_SLT:  res = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLL:  res = b << shamt;
            ALU_SRA:  res = $unsigned($signed(b) >>> shamt);
            ALU_SLTU: res = {31'b0, (a < b)};
            ALU_ADDU: res = sum;
            ALU_SUBU: res = diff;
            ALU_SLLV: res = b << a[4:0];
            ALU_SRLV: res = b >> a[4:0];
            ALU_LUI:  res = {b[15:0], 16'h0000};
            default:  res = '0;
        endcase
    end

    assign zero = (res == '0);

endmodule : alu_unit
`default_nettype wire

// File: rtl/regs_alu_cp0.sv
`default_nettype none
// ============================================================================
// Module      : regs_alu_cp0
// Description : Multicycle MIPS execution core: 32x32 GPR file, ALU and CP0
//               register bank. Reads are combinational, writes on posedge.
// Revision    : 1.0  initial release
// ============================================================================
module regs_alu_cp0
    import regs_alu_cp0_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int EPC_IDX   = CP0_EPC,
    parameter int CAUSE_IDX = CP0_CAUSE
) (
    input  wire logic        clk,
    input  wire logic        rst,
    regs_alu_cp0_if.slave    bus
);

    logic [DATA_W-1:0] gpr [NREG];
    logic [DATA_W-1:0] cp0 [NREG];
    logic              mtc0_blocked;

    // GPR write port; r0 is never written so it stays zero after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
        end else if (bus.reg_we && (bus.reg_W_addr != 5'd0)) begin
            gpr[bus.reg_W_addr] <= bus.wdata;
        end
    end

    // Combinational reads, no write bypass
    assign bus.rdata_A = (bus.reg_R_addr_A == 5'd0) ? '0 : gpr[bus.reg_R_addr_A];
    assign bus.rdata_B = (bus.reg_R_addr_B == 5'd0) ? '0 : gpr[bus.reg_R_addr_B];

    // Exception-side writes own EPC/Cause; an mtc0 aimed at the same entry is dropped
    assign mtc0_blocked = (bus.WriteEPC   && (int'(bus.c0_wr_addr) == EPC_IDX)) ||
                          (bus.WriteCause && (int'(bus.c0_wr_addr) == CAUSE_IDX));

    // CP0 bank: mtc0, EPC capture and Cause exception-code update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) cp0[i] <= '0;
        end else begin
            if (bus.c0_reg_we && !mtc0_blocked) begin
                cp0[bus.c0_wr_addr] <= bus.c0_w_data;
            end
            if (bus.WriteEPC) begin
                cp0[EPC_IDX] <= bus.pc_i;
            end
            if (bus.WriteCause) begin
                cp0[CAUSE_IDX][6:2] <= bus.InTcause;
            end
        end
    end

    assign bus.c0_r_data = cp0[bus.c0_rd_addr];
    assign bus.epc_o     = cp0[EPC_IDX];

    alu_unit u_alu (
        .a        (bus.A),
        .b        (bus.B),
        .op       (bus.ALU_operation),
        .shamt    (bus.shamt),
        .res      (bus.res),
        .zero     (bus.zero),
        .overflow (bus.overflow)
    );

endmodule : regs_alu_cp0
`default_nettype wire

// File: tb/tb_regs_alu_cp0.sv
`default_nettype none
// ============================================================================
// Module      : tb_regs_alu_cp0
// Description : Directed self-checking bench for regs_alu_cp0.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regs_alu_cp0;
    import regs_alu_cp0_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    regs_alu_cp0_if bus ();

    regs_alu_cp0 #(
        .NREG      (32),
        .EPC_IDX   (14),
        .CAUSE_IDX (13)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then let outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [4:0] sh);
        bus.A = a;
        bus.B = b;
        bus.ALU_operation = op;
        bus.shamt = sh;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.reg_R_addr_A = 5'd5;
        bus.reg_R_addr_B = 5'd0;
        bus.reg_W_addr   = 5'd0;
        bus.wdata        = '0;
        bus.reg_we       = 1'b0;
        bus.A            = '0;
        bus.B            = '0;
        bus.ALU_operation = ALU_AND;
        bus.shamt        = '0;
        bus.c0_rd_addr   = 5'd0;
        bus.c0_wr_addr   = 5'd0;
        bus.c0_w_data    = '0;
        bus.c0_reg_we    = 1'b0;
        bus.pc_i         = '0;
        bus.InTcause     = '0;
        bus.WriteEPC     = 1'b0;
        bus.WriteCause   = 1'b0;

        // Reset state; ALU stays live during reset
        #12;
        chk("rst_rdata_A", bus.rdata_A, 32'h0);
        chk("rst_epc",     bus.epc_o,   32'h0);
        alu(32'd3, 32'd4, ALU_ADD, 5'd0);
        chk("rst_alu_add", bus.res, 32'd7);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // GPR write r5, no bypass before the edge
        @(negedge clk);
        bus.reg_W_addr = 5'd5;
        bus.wdata      = 32'hDEADBEEF;
        bus.reg_we     = 1'b1;
        bus.reg_R_addr_A = 5'd5;
        #1;
        chk("gpr_nobypass", bus.rdata_A, 32'h0);
        tick();
        bus.reg_we = 1'b0;
        #1;
        chk("gpr_r5_A", bus.rdata_A, 32'hDEADBEEF);
        bus.reg_R_addr_B = 5'd5;
        #1;
        chk("gpr_r5_B", bus.rdata_B, 32'hDEADBEEF);

        // r0 ignores writes
        bus.reg_W_addr = 5'd0;
        bus.wdata      = 32'h00001234;
        bus.reg_we     = 1'b1;
        tick();
        bus.reg_we = 1'b0;
        bus.reg_R_addr_A = 5'd0;
        #1;
        chk("gpr_r0", bus.rdata_A, 32'h0);

        // ALU vectors
        alu(32'h7FFFFFFF, 32'h1, ALU_ADD, 5'd0);
        chk("add_res", bus.res, 32'h80000000);
        chk("add_ovf", {31'b0, bus.overflow}, 32'd1);
        alu(32'h7FFFFFFF, 32'h1, ALU_ADDU, 5'd0);
        chk("addu_res", bus.res, 32'h80000000);
        chk("addu_ovf", {31'b0, bus.overflow}, 32'd0);
        alu(32'd5, 32'd5, ALU_SUB, 5'd0);
        chk("sub_res",  bus.res, 32'h0);
        chk("sub_zero", {31'b0, bus.zero}, 32'd1);
        chk("sub_novf", {31'b0, bus.overflow}, 32'd0);
        alu(32'h80000000, 32'h1, ALU_SUB, 5'd0);
        chk("sub_ovf_res", bus.res, 32'h7FFFFFFF);
        chk("sub_ovf",     {31'b0, bus.overflow}, 32'd1);
        alu(32'hFFFFFFFF, 32'h1, ALU_SLT, 5'd0);
        chk("slt", bus.res, 32'd1);
        alu(32'hFFFFFFFF, 32'h1, ALU_SLTU, 5'd0);
        chk("sltu",      bus.res, 32'd0);
        chk("sltu_zero", {31'b0, bus.zero}, 32'd1);
        alu(32'h0, 32'h80000000, ALU_SRA, 5'd4);
        chk("sra", bus.res, 32'hF8000000);
        alu(32'h0, 32'h80000000, ALU_SRL, 5'd4);
        chk("srl", bus.res, 32'h08000000);
        alu(32'h0, 32'h80000000, ALU_SLL, 5'd4);
        chk("sll",      bus.res, 32'h0);
        chk("sll_zero", {31'b0, bus.zero}, 32'd1);
        alu(32'h00000004, 32'h00000001, ALU_SLLV, 5'd0);
        chk("sllv", bus.res, 32'h00000010);
        alu(32'h00000024, 32'h80000000, ALU_SRLV, 5'd0);
        chk("srlv", bus.res, 32'h08000000);
        alu(32'h0, 32'hABCD1234, ALU_LUI, 5'd0);
        chk("lui", bus.res, 32'h12340000);
        alu(32'h0000F0F0, 32'h0000FF00, ALU_AND, 5'd0);
        chk("and", bus.res, 32'h0000F000);
        alu(32'h0000F0F0, 32'h0000FF00, ALU_XOR, 5'd0);
        chk("xor", bus.res, 32'h00000FF0);
        alu(32'h0000F0F0, 32'h0000FF00, ALU_NOR, 5'd0);
        chk("nor", bus.res, 32'hFFFF000F);
        alu(32'h00000001, 32'h00000002, ALU_SUBU, 5'd0);
        chk("subu", bus.res, 32'hFFFFFFFF);

        // Exception capture of EPC and Cause
        @(negedge clk);
        bus.WriteEPC   = 1'b1;
        bus.WriteCause = 1'b1;
        bus.pc_i       = 32'h100;
        bus.InTcause   = 5'd8;
        tick();
        bus.WriteEPC   = 1'b0;
        bus.WriteCause = 1'b0;
        bus.c0_rd_addr = 5'd13;
        #1;
        chk("epc_capture", bus.epc_o,     32'h100);
        chk("cause_code",  bus.c0_r_data, 32'h20);

        // mtc0 index 11
        bus.c0_reg_we  = 1'b1;
        bus.c0_wr_addr = 5'd11;
        bus.c0_w_data  = 32'hABCD;
        tick();
        bus.c0_reg_we  = 1'b0;
        bus.c0_rd_addr = 5'd11;
        #1;
        chk("mtc0_11", bus.c0_r_data, 32'hABCD);

        // EPC conflict: exception write wins
        bus.c0_reg_we  = 1'b1;
        bus.c0_wr_addr = 5'd14;
        bus.c0_w_data  = 32'h55;
        bus.WriteEPC   = 1'b1;
        bus.pc_i       = 32'h200;
        tick();
        bus.c0_reg_we  = 1'b0;
        bus.WriteEPC   = 1'b0;
        #1;
        chk("epc_conflict", bus.epc_o, 32'h200);

        // Cause: fill by mtc0, then conflicting write keeps non-code bits
        bus.c0_reg_we  = 1'b1;
        bus.c0_wr_addr = 5'd13;
        bus.c0_w_data  = 32'hFFFFFFFF;
        tick();
        bus.c0_w_data  = 32'h0;
        bus.WriteCause = 1'b1;
        bus.InTcause   = 5'd0;
        tick();
        bus.c0_reg_we  = 1'b0;
        bus.WriteCause = 1'b0;
        bus.c0_rd_addr = 5'd13;
        #1;
        chk("cause_conflict", bus.c0_r_data, 32'hFFFFFF83);

        // Non-conflicting same-edge writes both land (index 0 is writable)
        bus.c0_reg_we  = 1'b1;
        bus.c0_wr_addr = 5'd0;
        bus.c0_w_data  = 32'h77;
        bus.WriteEPC   = 1'b1;
        bus.pc_i       = 32'h300;
        tick();
        bus.c0_reg_we  = 1'b0;
        bus.WriteEPC   = 1'b0;
        bus.c0_rd_addr = 5'd0;
        #1;
        chk("mtc0_idx0", bus.c0_r_data, 32'h77);
        chk("epc_both",  bus.epc_o,     32'h300);

        // Mid-run asynchronous reset clears state without a clock edge
        @(negedge clk);
        #2;
        bus.reg_R_addr_A = 5'd5;
        bus.c0_rd_addr   = 5'd11;
        rst = 1'b0;
        #1;
        chk("areset_r5",   bus.rdata_A,   32'h0);
        chk("areset_epc",  bus.epc_o,     32'h0);
        chk("areset_cp0",  bus.c0_r_data, 32'h0);
        #10;
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regs_alu_cp0
`default_nettype wire
